l1i_miss_unit: RTL and testbench

- Handles L1 instruction-cache misses.
- Accepts one miss at a time from the L1I lookup stage.
- Arbitrates for the L2 through the req/grant handshake, issues the line-aligned physical address, then waits for the L2 return.
- Drives a one-cycle refill write into the L1I data/tag arrays; it sits directly upstream of the L2 cache on its L1I port.

---
 rtl/l1i_miss_unit_if.sv | 46 ++++
 rtl/l1i_miss_unit.sv | 204 ++++++++++++++++++++
 tb/tb_l1i_miss_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1i_miss_unit_if.sv
// ----------------------------------------------------------------------------
// l1i_miss_unit_if
// L1I miss unit <-> L2 request/return bus.
//   master : the miss unit (drives request, receives grant and returned line)
//   slave  : the L2 port (drives grant and returned line, receives request)
// Signals:
//   l2_req           request L2 arbitration
//   l2_grant         grant, combinational from L2 free & l2_req
//   l2_req_valid     request valid, sampled by L2 while free
//   l2_req_paddr     line-aligned physical address
//   l2_req_cached    cacheability of the request
//   l2_returned      one-cycle pulse, returned line valid
//   l2_returned_data returned line
// ----------------------------------------------------------------------------
interface l1i_miss_unit_if #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH  = 128
);
    logic                   l2_req;
    logic                   l2_grant;
    logic                   l2_req_valid;
    logic [PADDR_WIDTH-1:0] l2_req_paddr;
    logic                   l2_req_cached;
    logic                   l2_returned;
    logic [LINE_WIDTH-1:0]  l2_returned_data;

    modport master (
        output l2_req,
        output l2_req_valid,
        output l2_req_paddr,
        output l2_req_cached,
        input  l2_grant,
        input  l2_returned,
        input  l2_returned_data
    );

    modport slave (
        input  l2_req,
        input  l2_req_valid,
        input  l2_req_paddr,
        input  l2_req_cached,
        output l2_grant,
        output l2_returned,
        output l2_returned_data
    );
endinterface

// File: rtl/l1i_miss_unit.sv
// ----------------------------------------------------------------------------
// l1i_miss_unit
// Handles one L1 instruction-cache miss at a time: accepts the miss, arbitrates
// for the L2, issues the line-aligned address, waits for the line and drives a
// one-cycle refill write into the L1I arrays.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_miss_valid/paddr/cached     miss from the L1I lookup stage
//   o_miss_ready                  unit idle, miss accepted when valid
//   i_flush                       kill pending miss (redirect / fence.i)
//   l2                            L2 request/return bus (master side)
//   o_refill_valid/paddr/cached/data  one-cycle refill write
//   o_timeout                     sticky, WAIT reached TIMEOUT_CYCLES
//   o_miss_count                  accepted-miss counter, wraps
// ----------------------------------------------------------------------------
module l1i_miss_unit #(
    parameter int unsigned PADDR_WIDTH         = 32,
    parameter int unsigned CACHELINE_SIZE      = 16,
    parameter int unsigned CACHELINE_SIZE_BITS = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 1024,
    parameter int unsigned TIMEOUT_BITS        = 11
) (
    input  logic                        i_clk,
    input  logic                        i_rst,

    input  logic                        i_miss_valid,
    input  logic [PADDR_WIDTH-1:0]      i_miss_paddr,
    input  logic                        i_miss_cached,
    output logic                        o_miss_ready,
    input  logic                        i_flush,

    l1i_miss_unit_if.master             l2,

    output logic                        o_refill_valid,
    output logic [PADDR_WIDTH-1:0]      o_refill_paddr,
    output logic                        o_refill_cached,
    output logic [CACHELINE_SIZE*8-1:0] o_refill_data,

    output logic                        o_timeout,
    output logic [31:0]                 o_miss_count
);

    typedef logic [PADDR_WIDTH-1:0]      paddr_t;
    typedef logic [CACHELINE_SIZE*8-1:0] icache_data_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StRefill
    } state_e;

    localparam paddr_t LineMask =
        ~PADDR_WIDTH'((64'd1 << CACHELINE_SIZE_BITS) - 64'd1);
    localparam logic [TIMEOUT_BITS-1:0] TmoMax  = TIMEOUT_BITS'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_BITS-1:0] TmoLast = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    paddr_t                  paddr_q, paddr_d;
    logic                    cached_q, cached_d;
    icache_data_entry_t      data_q, data_d;
    logic                    kill_q, kill_d;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [31:0]             miss_count_q, miss_count_d;

    logic accept;
    // A flush in the same cycle as the return also kills the line.
    logic kill_now;

    assign accept   = (state_q == StIdle) && i_miss_valid && !i_flush;
    assign kill_now = kill_q || i_flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StReq;
            end
            StReq: begin
                // Once granted the L2 has latched the request; a flush can no
                // longer withdraw it, so we must still wait for the return.
                if (l2.l2_grant)  state_d = StWait;
                else if (i_flush) state_d = StIdle;
            end
            StWait: begin
                if (l2.l2_returned) state_d = kill_now ? StIdle : StRefill;
            end
            StRefill: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_miss_ready     = 1'b0;
        l2.l2_req        = 1'b0;
        l2.l2_req_valid  = 1'b0;
        l2.l2_req_paddr  = '0;
        l2.l2_req_cached = 1'b0;
        o_refill_valid   = 1'b0;
        o_refill_paddr   = '0;
        o_refill_cached  = 1'b0;
        o_refill_data    = '0;
        case (state_q)
            StIdle: begin
                o_miss_ready = 1'b1;
            end
            StReq: begin
                l2.l2_req        = 1'b1;
                l2.l2_req_valid  = l2.l2_grant;
                l2.l2_req_paddr  = paddr_q;
                l2.l2_req_cached = cached_q;
            end
            StRefill: begin
                o_refill_valid  = 1'b1;
                o_refill_paddr  = paddr_q;
                o_refill_cached = cached_q;
                o_refill_data   = data_q;
            end
            default: ;
        endcase
    end

    assign o_timeout    = timeout_q;
    assign o_miss_count = miss_count_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        paddr_d      = paddr_q;
        cached_d     = cached_q;
        data_d       = data_q;
        kill_d       = kill_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
        miss_count_d = miss_count_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    paddr_d      = i_miss_paddr & LineMask;
                    cached_d     = i_miss_cached;
                    miss_count_d = miss_count_q + 32'd1;
                end
            end
            StReq: begin
                if (l2.l2_grant) begin
                    tmo_cnt_d = '0;
                    kill_d    = i_flush;
                end
            end
            StWait: begin
                if (tmo_cnt_q != TmoMax) tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TmoLast) timeout_d = 1'b1;
                if (i_flush) kill_d = 1'b1;
                if (l2.l2_returned) begin
                    if (kill_now) kill_d = 1'b0;
                    else          data_d = l2.l2_returned_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            paddr_q      <= '0;
            cached_q     <= 1'b0;
            data_q       <= '0;
            kill_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            miss_count_q <= '0;
        end else begin
            paddr_q      <= paddr_d;
            cached_q     <= cached_d;
            data_q       <= data_d;
            kill_q       <= kill_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_l1i_miss_unit.sv
// ----------------------------------------------------------------------------
// tb_l1i_miss_unit
// Directed self-checking bench for l1i_miss_unit. The bench plays the L2 slave
// on the interface. TIMEOUT_CYCLES is set to 8 to keep the timeout case short.
// ----------------------------------------------------------------------------
module tb_l1i_miss_unit;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_miss_valid;
    logic [31:0]  i_miss_paddr;
    logic         i_miss_cached;
    logic         o_miss_ready;
    logic         i_flush;
    logic         o_refill_valid;
    logic [31:0]  o_refill_paddr;
    logic         o_refill_cached;
    logic [127:0] o_refill_data;
    logic         o_timeout;
    logic [31:0]  o_miss_count;

    int checks   = 0;
    int failures = 0;
    int req_valid_seen = 0;
    int refill_seen    = 0;
    int rv0;
    int rf0;

    l1i_miss_unit_if #(.PADDR_WIDTH(32), .LINE_WIDTH(128)) l2_bus ();

    l1i_miss_unit #(
        .PADDR_WIDTH         (32),
        .CACHELINE_SIZE      (16),
        .CACHELINE_SIZE_BITS (4),
        .TIMEOUT_CYCLES      (8),
        .TIMEOUT_BITS        (4)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_miss_valid    (i_miss_valid),
        .i_miss_paddr    (i_miss_paddr),
        .i_miss_cached   (i_miss_cached),
        .o_miss_ready    (o_miss_ready),
        .i_flush         (i_flush),
        .l2              (l2_bus),
        .o_refill_valid  (o_refill_valid),
        .o_refill_paddr  (o_refill_paddr),
        .o_refill_cached (o_refill_cached),
        .o_refill_data   (o_refill_data),
        .o_timeout       (o_timeout),
        .o_miss_count    (o_miss_count)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge i_clk) begin
        if (l2_bus.l2_req_valid) req_valid_seen++;
        if (o_refill_valid)      refill_seen++;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full miss: immediate grant, return in the wait_cycles-th WAIT cycle.
    task automatic run_miss(input string tag, input logic [31:0] pa, input logic c,
                            input logic [127:0] d, input logic [31:0] exp_pa,
                            input int wait_cycles);
        i_miss_valid  = 1'b1;
        i_miss_paddr  = pa;
        i_miss_cached = c;
        tick();
        i_miss_valid       = 1'b0;
        l2_bus.l2_grant    = 1'b1;
        #1;
        check_eq({tag, "_req_valid"}, l2_bus.l2_req_valid, 1'b1);
        check_eq({tag, "_req_paddr"}, l2_bus.l2_req_paddr, exp_pa);
        check_eq({tag, "_req_cached"}, l2_bus.l2_req_cached, c);
        tick();
        l2_bus.l2_grant = 1'b0;
        repeat (wait_cycles - 1) tick();
        l2_bus.l2_returned      = 1'b1;
        l2_bus.l2_returned_data = d;
        tick();
        l2_bus.l2_returned      = 1'b0;
        l2_bus.l2_returned_data = '0;
        check_eq({tag, "_refill_valid"}, o_refill_valid, 1'b1);
        check_eq({tag, "_refill_paddr"}, o_refill_paddr, exp_pa);
        check_eq({tag, "_refill_cached"}, o_refill_cached, c);
        check_eq({tag, "_refill_data"}, o_refill_data, d);
        tick();
        check_eq({tag, "_refill_done"}, o_refill_valid, 1'b0);
        check_eq({tag, "_ready_after"}, o_miss_ready, 1'b1);
    endtask

    task automatic accept_miss(input logic [31:0] pa, input logic c);
        i_miss_valid  = 1'b1;
        i_miss_paddr  = pa;
        i_miss_cached = c;
        tick();
        i_miss_valid = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_miss_valid            = 1'($urandom_range(0, 1));
            i_miss_paddr            = $urandom;
            i_miss_cached           = 1'($urandom_range(0, 1));
            i_flush                 = 1'($urandom_range(0, 1));
            l2_bus.l2_grant         = 1'($urandom_range(0, 1));
            l2_bus.l2_returned      = 1'($urandom_range(0, 1));
            l2_bus.l2_returned_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        i_rst                   = 1'b0;
        i_miss_valid            = 1'b0;
        i_miss_paddr            = '0;
        i_miss_cached           = 1'b0;
        i_flush                 = 1'b0;
        l2_bus.l2_grant         = 1'b0;
        l2_bus.l2_returned      = 1'b0;
        l2_bus.l2_returned_data = '0;
        #1;
        check_eq("rst_ready", o_miss_ready, 1'b1);
        check_eq("rst_l2_req", l2_bus.l2_req, 1'b0);
        check_eq("rst_req_valid", l2_bus.l2_req_valid, 1'b0);
        check_eq("rst_req_paddr", l2_bus.l2_req_paddr, 32'h0);
        check_eq("rst_refill_valid", o_refill_valid, 1'b0);
        check_eq("rst_refill_paddr", o_refill_paddr, 32'h0);
        check_eq("rst_refill_data", o_refill_data, 128'h0);
        check_eq("rst_timeout", o_timeout, 1'b0);
        check_eq("rst_miss_count", o_miss_count, 32'd0);

        // Cached miss, 5-cycle acceptance-to-refill latency
        rv0 = req_valid_seen;
        rf0 = refill_seen;
        run_miss("cached", 32'h8000_1234, 1'b1, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff,
                 32'h8000_1230, 3);
        check_eq("cached_req_pulses", 32'(req_valid_seen - rv0), 32'd1);
        check_eq("cached_refill_pulses", 32'(refill_seen - rf0), 32'd1);
        check_eq("cached_count", o_miss_count, 32'd1);

        // Grant withheld for 4 cycles
        rv0 = req_valid_seen;
        accept_miss(32'h0000_4567, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("hold_l2_req", l2_bus.l2_req, 1'b1);
            check_eq("hold_req_valid", l2_bus.l2_req_valid, 1'b0);
            check_eq("hold_req_paddr", l2_bus.l2_req_paddr, 32'h0000_4560);
            tick();
        end
        l2_bus.l2_grant = 1'b1;
        #1;
        check_eq("hold_grant_valid", l2_bus.l2_req_valid, 1'b1);
        tick();
        l2_bus.l2_grant         = 1'b0;
        l2_bus.l2_returned      = 1'b1;
        l2_bus.l2_returned_data = 128'hcafe;
        tick();
        l2_bus.l2_returned = 1'b0;
        check_eq("hold_refill_valid", o_refill_valid, 1'b1);
        check_eq("hold_refill_data", o_refill_data, 128'hcafe);
        tick();
        check_eq("hold_req_pulses", 32'(req_valid_seen - rv0), 32'd1);
        check_eq("hold_count", o_miss_count, 32'd2);

        // Flush cases: none of these may produce a refill
        rv0 = req_valid_seen;
        rf0 = refill_seen;
        accept_miss(32'h2000_0040, 1'b1);
        i_flush = 1'b1;
        #1;
        check_eq("fl_req_valid", l2_bus.l2_req_valid, 1'b0);
        tick();
        i_flush = 1'b0;
        check_eq("fl_req_ready", o_miss_ready, 1'b1);
        check_eq("fl_req_l2_req", l2_bus.l2_req, 1'b0);
        check_eq("fl_req_pulses", 32'(req_valid_seen - rv0), 32'd0);
        check_eq("fl_req_count", o_miss_count, 32'd3);

        i_miss_valid = 1'b1;
        i_flush      = 1'b1;
        tick();
        i_miss_valid = 1'b0;
        i_flush      = 1'b0;
        check_eq("fl_idle_ready", o_miss_ready, 1'b1);
        check_eq("fl_idle_count", o_miss_count, 32'd3);

        accept_miss(32'h3000_0010, 1'b1);
        l2_bus.l2_grant = 1'b1;
        tick();
        l2_bus.l2_grant = 1'b0;
        i_flush         = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check_eq("fl_wait_busy", o_miss_ready, 1'b0);
        l2_bus.l2_returned = 1'b1;
        tick();
        l2_bus.l2_returned = 1'b0;
        check_eq("fl_wait_no_refill", o_refill_valid, 1'b0);
        check_eq("fl_wait_ready", o_miss_ready, 1'b1);

        accept_miss(32'h3000_0020, 1'b1);
        l2_bus.l2_grant = 1'b1;
        i_flush         = 1'b1;
        #1;
        check_eq("fl_grant_valid", l2_bus.l2_req_valid, 1'b1);
        tick();
        l2_bus.l2_grant = 1'b0;
        i_flush         = 1'b0;
        check_eq("fl_grant_waiting", o_miss_ready, 1'b0);
        l2_bus.l2_returned = 1'b1;
        tick();
        l2_bus.l2_returned = 1'b0;
        check_eq("fl_grant_ready", o_miss_ready, 1'b1);

        accept_miss(32'h3000_0030, 1'b1);
        l2_bus.l2_grant = 1'b1;
        tick();
        l2_bus.l2_grant    = 1'b0;
        l2_bus.l2_returned = 1'b1;
        i_flush            = 1'b1;
        tick();
        l2_bus.l2_returned = 1'b0;
        i_flush            = 1'b0;
        check_eq("fl_ret_ready", o_miss_ready, 1'b1);

        // Spurious return while idle
        l2_bus.l2_returned = 1'b1;
        tick();
        l2_bus.l2_returned = 1'b0;
        check_eq("spur_ready", o_miss_ready, 1'b1);
        tick();
        check_eq("flush_refill_pulses", 32'(refill_seen - rf0), 32'd0);
        check_eq("flush_count", o_miss_count, 32'd6);

        // Uncached miss
        run_miss("uncached", 32'h1000_0008, 1'b0, 128'h1234_5678, 32'h1000_0000, 3);
        check_eq("uncached_count", o_miss_count, 32'd7);
        check_eq("pre_timeout", o_timeout, 1'b0);

        // Timeout after 8 WAIT cycles, later return still refills
        accept_miss(32'h4000_0000, 1'b1);
        l2_bus.l2_grant = 1'b1;
        tick();
        l2_bus.l2_grant = 1'b0;
        repeat (7) tick();
        check_eq("tmo_7_cycles", o_timeout, 1'b0);
        tick();
        check_eq("tmo_8_cycles", o_timeout, 1'b1);
        repeat (3) tick();
        check_eq("tmo_still_waiting", o_miss_ready, 1'b0);
        l2_bus.l2_returned      = 1'b1;
        l2_bus.l2_returned_data = 128'hdead_beef;
        tick();
        l2_bus.l2_returned = 1'b0;
        check_eq("tmo_refill_valid", o_refill_valid, 1'b1);
        check_eq("tmo_refill_data", o_refill_data, 128'hdead_beef);
        tick();
        run_miss("after_tmo", 32'h5000_00ff, 1'b1, 128'h55, 32'h5000_00f0, 3);
        check_eq("tmo_sticky", o_timeout, 1'b1);
        check_eq("tmo_count", o_miss_count, 32'd9);

        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_eq("rst2_timeout", o_timeout, 1'b0);
        check_eq("rst2_count", o_miss_count, 32'd0);
        check_eq("rst2_ready", o_miss_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
